// File: rtl/bpu_param.sv
// -----------------------------------------------------------------------------
// bpu_param
//
// Branch prediction unit for the IF/ID front end. It contains:
//   * a direct-mapped, tagged BHT/BTB. Each entry holds a valid bit, a tag,
//     a target, a branch type and a 2-bit saturating counter.
//   * an optional circular return-address stack. It is built only when the
//     macro BPU_RAS_EN is defined. Without the macro, a RET that hits in the
//     table predicts its BTB target.
//   * a two-state misprediction correction FSM (IDLE / CORRECT).
//
// Parameters
//   BHT_DEPTH  number of table entries (power of two, 16..1024)
//   RAS_DEPTH  number of return-address stack entries (power of two, 2..32)
//
// Ports
//   clk, resetn            clock and asynchronous active-low reset
//   pl_flush               pipeline flush (exception/eret/tlb op). It returns
//                          the FSM to IDLE and empties the RAS.
//   correct_finish         fetch has redirected to correct_target
//   lk_valid/lk_pc/
//   lk_br_type             decode-stage lookup request
//   pred_valid/pred_taken/
//   pred_target/pred_hit/
//   pred_cnt               combinational prediction result
//   upd_*                  execute-stage resolution and table update
//   flush                  one-cycle pulse when a correction starts
//   is_correction          high while the FSM is in CORRECT
//   correct_target         redirect PC held during the correction
//
// Branch types: 0 none, 1 BRA, 2 J, 3 CALL, 4 RET.
// -----------------------------------------------------------------------------
module bpu_param #(
    parameter int BHT_DEPTH = 256,
    parameter int RAS_DEPTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pl_flush,
    input  logic        correct_finish,
    input  logic        lk_valid,
    input  logic [31:0] lk_pc,
    input  logic [2:0]  lk_br_type,
    output logic        pred_valid,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic        pred_hit,
    output logic [1:0]  pred_cnt,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [2:0]  upd_br_type,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_hit,
    input  logic [1:0]  upd_cnt,
    input  logic        upd_mispredict,
    output logic        flush,
    output logic        is_correction,
    output logic [31:0] correct_target
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam int TAG_W = 32 - IDX_W - 2;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BRA  = 3'd1;
    localparam logic [2:0] BR_J    = 3'd2;
    localparam logic [2:0] BR_CALL = 3'd3;
    localparam logic [2:0] BR_RET  = 3'd4;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_CORRECT = 1'b1
    } state_e;

    // -------------------------------------------------------------------------
    // Table storage. Only the valid bits are reset. The other fields are
    // don't-care until their valid bit is set.
    // -------------------------------------------------------------------------
    logic [BHT_DEPTH-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [BHT_DEPTH];
    logic [31:0]          tgt_q  [BHT_DEPTH];
    logic [2:0]           type_q [BHT_DEPTH];
    logic [1:0]           cnt_q  [BHT_DEPTH];

    state_e      state_q, state_d;
    logic        flush_q, flush_d;
    logic [31:0] ctgt_q, ctgt_d;

    // The low PC bits are always zero for aligned instructions, so they are
    // not used.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lk_pc[1:0], upd_pc[1:0]};

    // -------------------------------------------------------------------------
    // Lookup (combinational from the flop array)
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [31:0]      pc_add8;

    assign lk_idx  = lk_pc[IDX_W+1:2];
    assign lk_tag  = lk_pc[31:IDX_W+2];
    assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pc_add8 = lk_pc + 32'd8;

    assign pred_valid = lk_valid && (lk_br_type != BR_NONE) && (state_q == ST_IDLE);
    assign pred_hit   = lk_hit;
    assign pred_cnt   = lk_hit ? cnt_q[lk_idx] : 2'b00;

`ifdef BPU_RAS_EN
    // -------------------------------------------------------------------------
    // Return-address stack. ras_top_q points at the most recent push.
    // When the stack is full, a push wraps around onto the oldest slot.
    // -------------------------------------------------------------------------
    localparam int RAS_PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [RAS_PW:0] RAS_FULL = (RAS_PW+1)'(RAS_DEPTH);

    logic [31:0]       ras_mem [RAS_DEPTH];
    logic [RAS_PW-1:0] ras_top_q, ras_top_d;
    logic [RAS_PW:0]   ras_cnt_q, ras_cnt_d;
    logic              ras_push, ras_pop;

    assign ras_push = pred_valid && (lk_br_type == BR_CALL);
    assign ras_pop  = pred_valid && (lk_br_type == BR_RET) && (ras_cnt_q != '0);

    always_comb begin
        ras_top_d = ras_top_q;
        ras_cnt_d = ras_cnt_q;
        if (pl_flush) begin
            // A flush empties the stack and drops any push or pop.
            ras_cnt_d = '0;
        end else if (ras_push) begin
            ras_top_d = ras_top_q + RAS_PW'(1);
            if (ras_cnt_q != RAS_FULL) begin
                ras_cnt_d = ras_cnt_q + (RAS_PW+1)'(1);
            end
        end else if (ras_pop) begin
            ras_top_d = ras_top_q - RAS_PW'(1);
            ras_cnt_d = ras_cnt_q - (RAS_PW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ras_top_q <= '0;
            ras_cnt_q <= '0;
        end else begin
            ras_top_q <= ras_top_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ras_push && !pl_flush) begin
            ras_mem[ras_top_d] <= pc_add8;
        end
    end
`endif

    // Prediction follows the stored type of the hitting entry.
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = pc_add8;
        if (lk_hit) begin
            case (type_q[lk_idx])
                BR_BRA: begin
                    if (cnt_q[lk_idx][1]) begin
                        pred_taken  = 1'b1;
                        pred_target = tgt_q[lk_idx];
                    end
                end
                BR_J, BR_CALL: begin
                    pred_taken  = 1'b1;
                    pred_target = tgt_q[lk_idx];
                end
                BR_RET: begin
                    pred_taken  = 1'b1;
                    pred_target = tgt_q[lk_idx];
`ifdef BPU_RAS_EN
                    if (ras_cnt_q != '0) begin
                        pred_target = ras_mem[ras_top_q];
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Table update from execute. The table is written even during a
    // correction or a flush.
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_we;
    logic [1:0]       upd_cnt_new;

    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[31:IDX_W+2];
    assign upd_we  = upd_valid && (upd_br_type != BR_NONE);

    // A fresh entry starts weakly biased toward the observed direction.
    // An existing entry steps its carried counter, saturating at 00 and 11.
    always_comb begin
        upd_cnt_new = upd_cnt;
        if (!upd_hit) begin
            upd_cnt_new = upd_taken ? 2'b10 : 2'b01;
        end else if (upd_taken) begin
            if (upd_cnt != 2'b11) upd_cnt_new = upd_cnt + 2'b01;
        end else begin
            if (upd_cnt != 2'b00) upd_cnt_new = upd_cnt - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
        end else if (upd_we) begin
            valid_q[upd_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (upd_we) begin
            tag_q[upd_idx]  <= upd_tag;
            tgt_q[upd_idx]  <= upd_target;
            type_q[upd_idx] <= upd_br_type;
            cnt_q[upd_idx]  <= upd_cnt_new;
        end
    end

    // -------------------------------------------------------------------------
    // Correction FSM. A pipeline flush takes priority over a mispredict and
    // over correct_finish.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        flush_d = 1'b0;
        ctgt_d  = ctgt_q;
        if (pl_flush) begin
            state_d = ST_IDLE;
            ctgt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (upd_valid && upd_mispredict) begin
                        state_d = ST_CORRECT;
                        flush_d = 1'b1;
                        ctgt_d  = upd_taken ? upd_target : (upd_pc + 32'd8);
                    end
                end
                ST_CORRECT: begin
                    if (correct_finish) begin
                        state_d = ST_IDLE;
                        ctgt_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    ctgt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            flush_q <= 1'b0;
            ctgt_q  <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            ctgt_q  <= ctgt_d;
        end
    end

    assign flush          = flush_q;
    assign is_correction  = (state_q == ST_CORRECT);
    assign correct_target = ctgt_q;

endmodule

// File: tb/tb_bpu_param.sv
// -----------------------------------------------------------------------------
// tb_bpu_param
//
// Directed testbench for bpu_param. It uses hand-computed expected values.
// Inputs are driven 1 ns after the rising edge, and the combinational
// outputs are checked before the next rising edge.
// -----------------------------------------------------------------------------
module tb_bpu_param;

    localparam int BHT_DEPTH = 256;
    localparam int RAS_DEPTH = 8;
`ifdef BPU_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BRA  = 3'd1;
    localparam logic [2:0] BR_CALL = 3'd3;
    localparam logic [2:0] BR_RET  = 3'd4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        pl_flush;
    logic        correct_finish;
    logic        lk_valid;
    logic [31:0] lk_pc;
    logic [2:0]  lk_br_type;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        pred_hit;
    logic [1:0]  pred_cnt;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [2:0]  upd_br_type;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_hit;
    logic [1:0]  upd_cnt;
    logic        upd_mispredict;
    logic        flush;
    logic        is_correction;
    logic [31:0] correct_target;

    int checks   = 0;
    int failures = 0;

    bpu_param #(
        .BHT_DEPTH(BHT_DEPTH),
        .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .pl_flush       (pl_flush),
        .correct_finish (correct_finish),
        .lk_valid       (lk_valid),
        .lk_pc          (lk_pc),
        .lk_br_type     (lk_br_type),
        .pred_valid     (pred_valid),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .pred_hit       (pred_hit),
        .pred_cnt       (pred_cnt),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_br_type    (upd_br_type),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_hit        (upd_hit),
        .upd_cnt        (upd_cnt),
        .upd_mispredict (upd_mispredict),
        .flush          (flush),
        .is_correction  (is_correction),
        .correct_target (correct_target)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end else begin
            $display("ok   %s got=%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic [2:0] t);
        lk_valid   = 1'b1;
        lk_pc      = pc;
        lk_br_type = t;
        #1;
    endtask

    task automatic lk_clear();
        lk_valid   = 1'b0;
        lk_pc      = '0;
        lk_br_type = BR_NONE;
    endtask

    task automatic update(input logic [31:0] pc, input logic [2:0] t, input logic taken,
                          input logic [31:0] tgt, input logic hit, input logic [1:0] cnt,
                          input logic misp);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_br_type    = t;
        upd_taken      = taken;
        upd_target     = tgt;
        upd_hit        = hit;
        upd_cnt        = cnt;
        upd_mispredict = misp;
    endtask

    task automatic upd_clear();
        upd_valid      = 1'b0;
        upd_pc         = '0;
        upd_br_type    = BR_NONE;
        upd_taken      = 1'b0;
        upd_target     = '0;
        upd_hit        = 1'b0;
        upd_cnt        = 2'b00;
        upd_mispredict = 1'b0;
    endtask

    initial begin
        resetn         = 1'b0;
        pl_flush       = 1'b0;
        correct_finish = 1'b0;
        lk_clear();
        upd_clear();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        lookup(32'h00400010, BR_BRA);
        check_eq("rst_flush", flush, 1'b0);
        check_eq("rst_is_corr", is_correction, 1'b0);
        check_eq("rst_ctgt", correct_target, 32'h0);
        check_eq("rst_hit", pred_hit, 1'b0);
        resetn = 1'b1;
        tick();

        // Cold miss
        lookup(32'h00400010, BR_BRA);
        check_eq("miss_valid", pred_valid, 1'b1);
        check_eq("miss_hit", pred_hit, 1'b0);
        check_eq("miss_taken", pred_taken, 1'b0);
        check_eq("miss_target", pred_target, 32'h00400018);

        // First update. A lookup in the same cycle still sees the old entry.
        update(32'h00400010, BR_BRA, 1'b1, 32'h00400100, 1'b0, 2'b00, 1'b0);
        #1;
        check_eq("same_cyc_hit", pred_hit, 1'b0);
        tick();
        upd_clear();
        check_eq("new_hit", pred_hit, 1'b1);
        check_eq("new_cnt", pred_cnt, 2'b10);
        check_eq("new_taken", pred_taken, 1'b1);
        check_eq("new_target", pred_target, 32'h00400100);

        // Counter walks down and saturates, then saturates at the top.
        update(32'h00400010, BR_BRA, 1'b0, 32'h00400100, 1'b1, 2'b10, 1'b0);
        tick();
        check_eq("cnt_dn1", pred_cnt, 2'b01);
        check_eq("cnt_dn1_taken", pred_taken, 1'b0);
        check_eq("cnt_dn1_target", pred_target, 32'h00400018);
        update(32'h00400010, BR_BRA, 1'b0, 32'h00400100, 1'b1, 2'b01, 1'b0);
        tick();
        check_eq("cnt_dn2", pred_cnt, 2'b00);
        check_eq("cnt_dn2_taken", pred_taken, 1'b0);
        update(32'h00400010, BR_BRA, 1'b0, 32'h00400100, 1'b1, 2'b00, 1'b0);
        tick();
        check_eq("cnt_sat_lo", pred_cnt, 2'b00);
        update(32'h00400010, BR_BRA, 1'b1, 32'h00400100, 1'b1, 2'b11, 1'b0);
        tick();
        upd_clear();
        check_eq("cnt_sat_hi", pred_cnt, 2'b11);
        check_eq("cnt_sat_hi_taken", pred_taken, 1'b1);

        // An update with type 0 does not write. An aliasing index with a
        // different tag misses.
        update(32'h00400200, BR_NONE, 1'b1, 32'h00400999, 1'b0, 2'b00, 1'b0);
        tick();
        upd_clear();
        lookup(32'h00400200, BR_BRA);
        check_eq("type0_nowrite", pred_hit, 1'b0);
        lookup(32'h00400010 + BHT_DEPTH * 4, BR_BRA);
        check_eq("tag_alias_miss", pred_hit, 1'b0);

        // CALL / RET entries
        update(32'h00400020, BR_CALL, 1'b1, 32'h00401000, 1'b0, 2'b00, 1'b0);
        tick();
        update(32'h00401000, BR_RET, 1'b1, 32'h00400500, 1'b0, 2'b00, 1'b0);
        tick();
        upd_clear();
        lookup(32'h00400020, BR_CALL);
        check_eq("call_hit", pred_hit, 1'b1);
        check_eq("call_taken", pred_taken, 1'b1);
        check_eq("call_target", pred_target, 32'h00401000);
        tick();
        lookup(32'h00401000, BR_RET);
        check_eq("ret_taken", pred_taken, 1'b1);
        check_eq("ret_target", pred_target, RAS_ON ? 32'h00400028 : 32'h00400500);
        tick();
        lookup(32'h00401000, BR_RET);
        check_eq("ret_empty_target", pred_target, 32'h00400500);
        tick();

        // RAS overflow: RAS_DEPTH+1 calls, then RAS_DEPTH+1 returns.
        for (int k = 0; k <= RAS_DEPTH; k++) begin
            lookup(32'h00410000 + 32'(16 * k), BR_CALL);
            tick();
        end
        for (int r = 0; r <= RAS_DEPTH; r++) begin
            logic [31:0] exp_t;
            exp_t = 32'h00400500;
            if (RAS_ON && r < RAS_DEPTH) exp_t = 32'h00410000 + 32'(16 * (RAS_DEPTH - r)) + 32'd8;
            lookup(32'h00401000, BR_RET);
            check_eq($sformatf("ovf_ret%0d", r), pred_target, exp_t);
            tick();
        end
        lk_clear();

        // Mispredict (not taken) -> correction
        update(32'h00400040, BR_BRA, 1'b0, 32'h00400300, 1'b0, 2'b00, 1'b1);
        tick();
        upd_clear();
        lookup(32'h00400010, BR_BRA);
        check_eq("mp_flush", flush, 1'b1);
        check_eq("mp_is_corr", is_correction, 1'b1);
        check_eq("mp_ctgt", correct_target, 32'h00400048);
        check_eq("mp_pvalid", pred_valid, 1'b0);
        tick();
        check_eq("mp_flush_once", flush, 1'b0);
        check_eq("mp_is_corr2", is_correction, 1'b1);
        check_eq("mp_pvalid2", pred_valid, 1'b0);
        // A second mispredict during the correction updates the table only.
        update(32'h00400080, BR_BRA, 1'b1, 32'h00400abc, 1'b0, 2'b00, 1'b1);
        tick();
        upd_clear();
        check_eq("mp2_no_flush", flush, 1'b0);
        check_eq("mp2_ctgt_kept", correct_target, 32'h00400048);
        lookup(32'h00400080, BR_BRA);
        check_eq("mp2_written", pred_hit, 1'b1);
        lookup(32'h00400040, BR_BRA);
        check_eq("mp_entry_hit", pred_hit, 1'b1);
        check_eq("mp_entry_cnt", pred_cnt, 2'b01);
        correct_finish = 1'b1;
        #1;
        check_eq("cf_still_corr", is_correction, 1'b1);
        tick();
        correct_finish = 1'b0;
        check_eq("cf_idle", is_correction, 1'b0);
        check_eq("cf_ctgt_clr", correct_target, 32'h0);
        check_eq("cf_pvalid", pred_valid, 1'b1);

        // Mispredict together with pl_flush. pl_flush wins and the RAS empties.
        lookup(32'h00400020, BR_CALL);
        tick();
        lk_clear();
        update(32'h00400060, BR_BRA, 1'b1, 32'h00400600, 1'b0, 2'b00, 1'b1);
        pl_flush = 1'b1;
        tick();
        pl_flush = 1'b0;
        upd_clear();
        check_eq("plf_no_flush", flush, 1'b0);
        check_eq("plf_idle", is_correction, 1'b0);
        check_eq("plf_ctgt", correct_target, 32'h0);
        lookup(32'h00401000, BR_RET);
        check_eq("plf_ras_empty", pred_target, 32'h00400500);
        lookup(32'h00400060, BR_BRA);
        check_eq("plf_written_hit", pred_hit, 1'b1);
        check_eq("plf_written_cnt", pred_cnt, 2'b10);
        check_eq("plf_written_tgt", pred_target, 32'h00400600);
        lk_clear();

        // Asynchronous reset in the middle of a correction
        update(32'h00400070, BR_BRA, 1'b0, 32'h0, 1'b0, 2'b00, 1'b1);
        tick();
        upd_clear();
        check_eq("ar_pre_corr", is_correction, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        lookup(32'h00400010, BR_BRA);
        check_eq("ar_is_corr", is_correction, 1'b0);
        check_eq("ar_flush", flush, 1'b0);
        check_eq("ar_ctgt", correct_target, 32'h0);
        check_eq("ar_valid_clr", pred_hit, 1'b0);
        lk_clear();
        tick();
        resetn = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
